// File: rtl/regfile_write_buffer_if.sv
// Handshake and data bundle between producers, the write buffer and the register file.
// slave is the buffer's view; master is the view of whatever surrounds it.
interface regfile_write_buffer_if #(
  parameter int unsigned width    = 32,
  parameter int unsigned n        = 5,
  parameter int unsigned depth    = 4,
  parameter int unsigned logDepth = 2
);
  logic                ENQ_EN_WRITE;
  logic [n-1:0]        ENQ_INDEX_WRITE;
  logic [width-1:0]    ENQ_DATA_WRITE;
  logic                ENQ_RDY_READ;
  logic                DRAIN_EN_WRITE;
  logic                RF_WRITE_EN;
  logic [n-1:0]        RF_WRITE_INDEX;
  logic [width-1:0]    RF_WRITE_DATA;
  logic [n-1:0]        LOOKUP_INDEX_WRITE;
  logic [n-1:0]        RF_READ_REQ;
  logic [width-1:0]    RF_READ_RESP;
  logic                LOOKUP_HIT_READ;
  logic [width-1:0]    LOOKUP_DATA_READ;
  logic [logDepth:0]   COUNT_READ;

  modport slave (
    input  ENQ_EN_WRITE, ENQ_INDEX_WRITE, ENQ_DATA_WRITE, DRAIN_EN_WRITE,
    input  LOOKUP_INDEX_WRITE, RF_READ_RESP,
    output ENQ_RDY_READ, RF_WRITE_EN, RF_WRITE_INDEX, RF_WRITE_DATA,
    output RF_READ_REQ, LOOKUP_HIT_READ, LOOKUP_DATA_READ, COUNT_READ
  );

  modport master (
    output ENQ_EN_WRITE, ENQ_INDEX_WRITE, ENQ_DATA_WRITE, DRAIN_EN_WRITE,
    output LOOKUP_INDEX_WRITE, RF_READ_RESP,
    input  ENQ_RDY_READ, RF_WRITE_EN, RF_WRITE_INDEX, RF_WRITE_DATA,
    input  RF_READ_REQ, LOOKUP_HIT_READ, LOOKUP_DATA_READ, COUNT_READ
  );
endinterface

// File: rtl/regfile_write_buffer.sv
// Write-side FIFO in front of a single-write-port register file, with read forwarding
// of the youngest buffered value for a looked-up index.
module regfile_write_buffer #(
  parameter int unsigned width    = 32,
  parameter int unsigned n        = 5,
  parameter int unsigned depth    = 4,
  parameter int unsigned logDepth = 2
) (
  input logic                    CLK,
  input logic                    RST_N,
  regfile_write_buffer_if.slave  bus
);

  localparam logic [logDepth:0] DepthCnt = (logDepth + 1)'(depth);

  logic [width-1:0]    data_q [depth];
  logic [n-1:0]        idx_q  [depth];
  logic [depth-1:0]    valid_q;
  logic [logDepth-1:0] head_q, tail_q;
  logic [logDepth:0]   count_q;

  logic enq_rdy, enq_acc, deq;
  logic             hit;
  logic [width-1:0] fwd;

  // Ready depends on occupancy only, never on the drain side.
  assign enq_rdy = RST_N && (count_q != DepthCnt);
  assign enq_acc = bus.ENQ_EN_WRITE && enq_rdy;
  assign deq     = RST_N && (count_q != '0) && bus.DRAIN_EN_WRITE;

  assign bus.ENQ_RDY_READ     = enq_rdy;
  assign bus.RF_WRITE_EN      = deq;
  assign bus.RF_WRITE_INDEX   = idx_q[head_q];
  assign bus.RF_WRITE_DATA    = data_q[head_q];
  assign bus.RF_READ_REQ      = bus.LOOKUP_INDEX_WRITE;
  assign bus.LOOKUP_HIT_READ  = hit;
  assign bus.LOOKUP_DATA_READ = fwd;
  assign bus.COUNT_READ       = count_q;

  // Pointer, occupancy and valid-bit tracking.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (enq_acc) begin
        tail_q          <= tail_q + 1'b1;
        valid_q[tail_q] <= 1'b1;
      end
      if (deq) begin
        head_q          <= head_q + 1'b1;
        valid_q[head_q] <= 1'b0;
      end
      count_q <= count_q + (logDepth + 1)'(enq_acc) - (logDepth + 1)'(deq);
    end
  end

  // Entry payload storage; contents are meaningless unless the valid bit is set.
  always_ff @(posedge CLK) begin
    if (enq_acc) begin
      data_q[tail_q] <= bus.ENQ_DATA_WRITE;
      idx_q[tail_q]  <= bus.ENQ_INDEX_WRITE;
    end
  end

  // Scan oldest to youngest so the youngest match overrides; the head being drained
  // this cycle still forwards because the register file has not captured it yet.
  always_comb begin
    logic [logDepth-1:0] slot;
    hit  = 1'b0;
    fwd  = bus.RF_READ_RESP;
    slot = '0;
    for (int unsigned i = 0; i < depth; i++) begin
      slot = head_q + logDepth'(i);
      if (valid_q[slot] && (idx_q[slot] == bus.LOOKUP_INDEX_WRITE)) begin
        hit = 1'b1;
        fwd = data_q[slot];
      end
    end
  end

endmodule
